reset_sequencer: RTL and testbench

//  Parametrised successor to the board power-on reset generator: holds CHANNELS reset outputs

---
 rtl/reset_sequencer_pkg.sv | 20 ++
 rtl/reset_sequencer_if.sv | 22 ++
 rtl/button_debouncer.sv | 66 ++++++
 rtl/reset_sequencer.sv | 124 ++++++++++++
 tb/tb_reset_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer and its button front end.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_e;

  localparam logic [7:0] TRIG_COUNT_MAX = 8'hFF;

  // Channel index width: enough for up to 16 channels plus one past the last.
  localparam int IDX_W = 5;

  // Saturating increment for the trigger counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == TRIG_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Trigger inputs and sequenced reset outputs of the reset sequencer.
// The slave side is the sequencer itself; the master side is the board/command logic.
interface reset_sequencer_if #(
  parameter int CHANNELS = 4
);
  logic                btn_n;
  logic                soft_rst_req;
  logic [CHANNELS-1:0] rst_out;
  logic                seq_busy;
  logic                seq_done;
  logic [7:0]          trig_count;

  modport master (
    output btn_n, soft_rst_req,
    input  rst_out, seq_busy, seq_done, trig_count
  );

  modport slave (
    input  btn_n, soft_rst_req,
    output rst_out, seq_busy, seq_done, trig_count
  );
endinterface

// File: rtl/button_debouncer.sv
// Board button front end: two-flop synchroniser, stability-count debounce, and a
// one-cycle pulse on each debounced high-to-low transition (a press).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic level,
  output logic fall_pulse
);

  localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Power-up values match the reset values so the button reads as released from the start.
  logic                 sync1_q = 1'b1;
  logic                 sync1_d;
  logic                 sync2_q = 1'b1;
  logic                 sync2_d;
  logic                 level_q = 1'b1;
  logic                 level_d;
  logic                 fall_q  = 1'b0;
  logic                 fall_d;
  logic [CNT_WIDTH-1:0] cnt_q   = '0;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Count consecutive samples that disagree with the debounced level; accept the new level
  // once it has been seen DEBOUNCE_CYCLES times in a row, any agreeing sample restarts the count.
  always_comb begin
    sync1_d = din_async;
    sync2_d = sync1_q;
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == STABLE_LAST) begin
        level_d = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Synchroniser and debounce state; reset returns to the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / triggered reset sequencer: holds all channel resets, then releases them in
// ascending order one stage delay apart. Restarts on soft request or debounced button press.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS           = 4,
  parameter int STAGE_DELAY_CYCLES = 20,
  parameter int DEBOUNCE_CYCLES    = 16,
  parameter int CNT_WIDTH          = 16
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] STAGE_LAST = CNT_WIDTH'(STAGE_DELAY_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(CHANNELS - 1);

  // Initial values give a complete sequence after configuration without any rst pulse.
  seq_state_e           state_q      = ST_HOLD;
  seq_state_e           state_d;
  logic [CNT_WIDTH-1:0] cnt_q        = '0;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [IDX_W-1:0]     idx_q        = '0;
  logic [IDX_W-1:0]     idx_d;
  logic [CHANNELS-1:0]  rst_out_q    = '1;
  logic [CHANNELS-1:0]  rst_out_d;
  logic                 seq_done_q   = 1'b0;
  logic                 seq_done_d;
  logic [7:0]           trig_count_q = '0;
  logic [7:0]           trig_count_d;

  logic btn_level;
  logic btn_fall;
  logic btn_press;
  logic trigger;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_btn (
    .clk       (clk),
    .rst       (rst),
    .din_async (bus.btn_n),
    .level     (btn_level),
    .fall_pulse(btn_fall)
  );

  // A press pulse always coincides with the new low level; qualifying on it keeps the trigger
  // tied to the debounced state. Soft request and press in the same cycle merge into one trigger.
  assign btn_press = btn_fall & ~btn_level;
  assign trigger   = bus.soft_rst_req | btn_press;

  // State register; rst reloads the power-up values and overrides any trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      rst_out_q    <= '1;
      seq_done_q   <= 1'b0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rst_out_q    <= rst_out_d;
      seq_done_q   <= seq_done_d;
      trig_count_q <= trig_count_d;
    end
  end

  // Next state: a trigger restarts from scratch; otherwise count out each stage and release
  // channel idx at the end of it (HOLD releases channel 0, RELEASE the rest).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    rst_out_d    = rst_out_q;
    seq_done_d   = seq_done_q;
    trig_count_d = trig_count_q;
    if (trigger) begin
      state_d      = ST_HOLD;
      cnt_d        = '0;
      idx_d        = '0;
      rst_out_d    = '1;
      seq_done_d   = 1'b0;
      trig_count_d = sat_inc(trig_count_q);
    end else begin
      unique case (state_q)
        ST_HOLD, ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            rst_out_d = rst_out_q & ~(CHANNELS'(1) << idx_q);
            cnt_d     = '0;
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  // Outputs come straight from registers so no reset line can glitch.
  always_comb begin
    bus.rst_out    = rst_out_q;
    bus.seq_busy   = |rst_out_q;
    bus.seq_done   = seq_done_q;
    bus.trig_count = trig_count_q;
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with 4 channels, 20-cycle stages, 16-cycle debounce.
module tb_reset_sequencer;

  localparam int CH = 4;
  localparam int SD = 20;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reset_sequencer_if #(.CHANNELS(CH)) bus_if ();

  reset_sequencer #(
    .CHANNELS          (CH),
    .STAGE_DELAY_CYCLES(SD),
    .DEBOUNCE_CYCLES   (DB),
    .CNT_WIDTH         (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // 10 ns clock; inputs driven and outputs sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Starting on the falling edge right after the sequence-start edge, walk the staircase
  // and check the value just before and just after every release edge.
  task automatic run_staircase(input string tag);
    logic [3:0] pre;
    logic [3:0] post;
    int         cur;
    cur = 0;
    for (int k = 0; k < CH; k++) begin
      pre  = 4'hF << k;
      post = 4'hF << (k + 1);
      tick(SD * (k + 1) - 1 - cur);
      cur = SD * (k + 1);
      checks++;
      if (bus_if.rst_out !== pre || bus_if.seq_busy !== 1'b1 || bus_if.seq_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s pre_stage%0d: rst_out=%b busy=%b done=%b, expected rst_out=%b busy=1 done=0",
                 tag, k, bus_if.rst_out, bus_if.seq_busy, bus_if.seq_done, pre);
      end
      tick(1);
      checks++;
      if (bus_if.rst_out !== post || bus_if.seq_busy !== (k != CH - 1) ||
          bus_if.seq_done !== (k == CH - 1)) begin
        errors++;
        $display("[TB] FAIL %s stage%0d: rst_out=%b busy=%b done=%b, expected rst_out=%b busy=%b done=%b",
                 tag, k, bus_if.rst_out, bus_if.seq_busy, bus_if.seq_done, post,
                 (k != CH - 1), (k == CH - 1));
      end
    end
  endtask

  // Three rst edges, then deassert; returns on the falling edge just after the last rst edge.
  task automatic apply_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_power_up();
    run_staircase("power_up");
    checks++;
    if (bus_if.trig_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL power_up_trig: got %0d expected 0", bus_if.trig_count);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus_if.rst_out !== 4'b1111 || bus_if.seq_busy !== 1'b1 || bus_if.seq_done !== 1'b0 ||
        bus_if.trig_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: rst_out=%b busy=%b done=%b trig=%0d, expected 1111 1 0 0",
               bus_if.rst_out, bus_if.seq_busy, bus_if.seq_done, bus_if.trig_count);
    end
    run_staircase("after_rst");
  endtask

  task automatic test_soft_after_done();
    bus_if.soft_rst_req = 1'b1;
    tick(1);
    bus_if.soft_rst_req = 1'b0;
    checks++;
    if (bus_if.rst_out !== 4'b1111 || bus_if.seq_done !== 1'b0 || bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL soft_restart: rst_out=%b done=%b trig=%0d, expected 1111 0 1",
               bus_if.rst_out, bus_if.seq_done, bus_if.trig_count);
    end
    run_staircase("soft_done");
  endtask

  task automatic test_mid_sequence();
    apply_reset();
    tick(50);
    checks++;
    if (bus_if.rst_out !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL mid_before: rst_out=%b expected 1100", bus_if.rst_out);
    end
    bus_if.soft_rst_req = 1'b1;
    tick(1);
    bus_if.soft_rst_req = 1'b0;
    checks++;
    if (bus_if.rst_out !== 4'b1111 || bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL mid_restart: rst_out=%b trig=%0d, expected 1111 1",
               bus_if.rst_out, bus_if.trig_count);
    end
    run_staircase("mid_seq");
  endtask

  task automatic test_button();
    apply_reset();
    tick(85);
    bus_if.btn_n = 1'b0;
    tick(5);
    bus_if.btn_n = 1'b1;
    tick(3);
    bus_if.btn_n = 1'b0;
    tick(18);
    checks++;
    if (bus_if.rst_out !== 4'b0000 || bus_if.trig_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL btn_early: rst_out=%b trig=%0d, expected 0000 0",
               bus_if.rst_out, bus_if.trig_count);
    end
    tick(1);
    checks++;
    if (bus_if.rst_out !== 4'b1111 || bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL btn_press: rst_out=%b trig=%0d, expected 1111 1",
               bus_if.rst_out, bus_if.trig_count);
    end
    tick(11);
    bus_if.btn_n = 1'b1;
    tick(40);
    checks++;
    if (bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL btn_single: trig=%0d expected 1", bus_if.trig_count);
    end
    bus_if.btn_n = 1'b0;
    tick(10);
    bus_if.btn_n = 1'b1;
    tick(40);
    checks++;
    if (bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL btn_glitch: trig=%0d expected 1", bus_if.trig_count);
    end
  endtask

  task automatic test_soft_and_button();
    apply_reset();
    tick(85);
    bus_if.btn_n = 1'b0;
    tick(18);
    bus_if.soft_rst_req = 1'b1;
    tick(1);
    bus_if.soft_rst_req = 1'b0;
    checks++;
    if (bus_if.rst_out !== 4'b1111 || bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL same_cycle: rst_out=%b trig=%0d, expected 1111 1",
               bus_if.rst_out, bus_if.trig_count);
    end
    tick(1);
    checks++;
    if (bus_if.trig_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL same_cycle_after: trig=%0d expected 1", bus_if.trig_count);
    end
    bus_if.btn_n = 1'b1;
    tick(40);
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      bus_if.soft_rst_req = 1'b1;
      tick(1);
      bus_if.soft_rst_req = 1'b0;
      tick(1);
      if (i == 253) begin
        checks++;
        if (bus_if.trig_count !== 8'd254) begin
          errors++;
          $display("[TB] FAIL sat_254: trig=%0d expected 254", bus_if.trig_count);
        end
      end
    end
    checks++;
    if (bus_if.trig_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL sat_255: trig=%0d expected 255", bus_if.trig_count);
    end
    rst                 = 1'b1;
    bus_if.soft_rst_req = 1'b1;
    tick(1);
    rst                 = 1'b0;
    bus_if.soft_rst_req = 1'b0;
    checks++;
    if (bus_if.trig_count !== 8'd0 || bus_if.rst_out !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL rst_vs_soft: trig=%0d rst_out=%b, expected 0 1111",
               bus_if.trig_count, bus_if.rst_out);
    end
    run_staircase("rst_vs_soft");
    checks++;
    if (bus_if.trig_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL rst_vs_soft_end: trig=%0d expected 0", bus_if.trig_count);
    end
  endtask

  initial begin
    bus_if.btn_n        = 1'b1;
    bus_if.soft_rst_req = 1'b0;
    test_power_up();
    test_reset();
    test_soft_after_done();
    test_mid_sequence();
    test_button();
    test_soft_and_button();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
